// File: rtl/noc_params.sv
//==============================================================================
// Module   : noc_params (package)
// Brief    : Shared NoC types: output ports, flit labels, per-VC route state.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package noc_params;

   localparam int DEST_ADDR_SIZE = 4;
   localparam int VC_NUM_DEFAULT = 2;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      EAST  = 3'd4
   } port_t;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   typedef enum logic [0:0] {
      VC_IDLE   = 1'b0,
      VC_ROUTED = 1'b1
   } vc_state_t;

   // Keeps the VC id field at least one bit wide when VC_NUM is 1.
   function automatic int vc_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vc_route_stage_if.sv
//==============================================================================
// Module   : vc_route_stage_if
// Brief    : Flit-in / route-out bundle of the per-VC route computation stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vc_route_stage_if
   import noc_params::*;
#(
   parameter int VC_NUM = VC_NUM_DEFAULT
) ();

   localparam int VC_ID_W = vc_id_width(VC_NUM);

   logic                      valid_i;
   flit_label_t               flit_label_i;
   logic [VC_ID_W-1:0]        vc_id_i;
   logic [DEST_ADDR_SIZE-1:0] x_dest_i;
   logic [DEST_ADDR_SIZE-1:0] y_dest_i;
   logic [VC_NUM-1:0]         release_i;
   logic [VC_NUM-1:0]         route_valid_o;
   port_t                     out_port_o [VC_NUM];
   logic                      err_o;

   modport master (
      output valid_i, flit_label_i, vc_id_i, x_dest_i, y_dest_i, release_i,
      input  route_valid_o, out_port_o, err_o
   );

   modport slave (
      input  valid_i, flit_label_i, vc_id_i, x_dest_i, y_dest_i, release_i,
      output route_valid_o, out_port_o, err_o
   );

endinterface

`default_nettype wire

// File: rtl/dor_route_fn.sv
//==============================================================================
// Module   : dor_route_fn
// Brief    : Combinational XY/YX dimension-order route function with optional
//            mesh-bound check (RC_ERR_CHECK_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dor_route_fn
   import noc_params::*;
#(
   parameter int X_CURRENT   = 0,
   parameter int Y_CURRENT   = 0,
   parameter int MESH_SIZE_X = 4,
   parameter int MESH_SIZE_Y = 4,
   parameter int YX_ROUTING  = 0
) (
   input  logic [DEST_ADDR_SIZE-1:0] x_dest,
   input  logic [DEST_ADDR_SIZE-1:0] y_dest,
   output port_t                     port,
   output logic                      out_of_range
);

   port_t x_port;
   port_t y_port;

   // Unsigned magnitude compares only; no subtraction, so no wrap-around.
   always_comb begin
      x_port = LOCAL;
      y_port = LOCAL;
      if (int'(x_dest) < X_CURRENT)      x_port = WEST;
      else if (int'(x_dest) > X_CURRENT) x_port = EAST;
      if (int'(y_dest) < Y_CURRENT)      y_port = NORTH;
      else if (int'(y_dest) > Y_CURRENT) y_port = SOUTH;

      if (YX_ROUTING != 0) port = (y_port != LOCAL) ? y_port : x_port;
      else                 port = (x_port != LOCAL) ? x_port : y_port;

      out_of_range = 1'b0;
`ifdef RC_ERR_CHECK_EN
      out_of_range = (int'(x_dest) >= MESH_SIZE_X) || (int'(y_dest) >= MESH_SIZE_Y);
      if (out_of_range) port = LOCAL;
`endif
   end

`ifndef RC_ERR_CHECK_EN
   // Mesh bounds are only consumed by the bound checker.
   logic unused_mesh;
   assign unused_mesh = (MESH_SIZE_X > 0) && (MESH_SIZE_Y > 0);
`endif

endmodule

`default_nettype wire

// File: rtl/vc_route_stage.sv
//==============================================================================
// Module   : vc_route_stage
// Brief    : Registered per-VC route computation for a 2D-mesh router input
//            port; sticky error flag enabled by RC_ERR_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vc_route_stage
   import noc_params::*;
#(
   parameter int X_CURRENT   = 0,
   parameter int Y_CURRENT   = 0,
   parameter int MESH_SIZE_X = 4,
   parameter int MESH_SIZE_Y = 4,
   parameter int VC_NUM      = VC_NUM_DEFAULT,
   parameter int YX_ROUTING  = 0
) (
   input  logic              clk,
   input  logic              rst,
   vc_route_stage_if.slave   rc
);

   localparam int VC_ID_W = vc_id_width(VC_NUM);

   vc_state_t         state_q [VC_NUM];
   vc_state_t         state_d [VC_NUM];
   port_t             port_q  [VC_NUM];
   port_t             port_d  [VC_NUM];
   logic [VC_NUM-1:0] vc_hit;
   logic              is_head;
   port_t             rc_port;
   logic              rc_oor;

   // One head per cycle at most, so a single shared route function suffices.
   dor_route_fn #(
      .X_CURRENT   (X_CURRENT),
      .Y_CURRENT   (Y_CURRENT),
      .MESH_SIZE_X (MESH_SIZE_X),
      .MESH_SIZE_Y (MESH_SIZE_Y),
      .YX_ROUTING  (YX_ROUTING)
   ) u_dor (
      .x_dest       (rc.x_dest_i),
      .y_dest       (rc.y_dest_i),
      .port         (rc_port),
      .out_of_range (rc_oor)
   );

   assign is_head = (rc.flit_label_i == HEAD) || (rc.flit_label_i == HEADTAIL);

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign vc_hit[v]           = rc.valid_i && (rc.vc_id_i == VC_ID_W'(v));
      assign rc.route_valid_o[v] = (state_q[v] == VC_ROUTED);
      assign rc.out_port_o[v]    = port_q[v];
   end

   // A same-cycle release frees the VC before the new head is considered.
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
         port_d[v]  = port_q[v];
         if (rc.release_i[v]) state_d[v] = VC_IDLE;
         if (vc_hit[v] && is_head && (state_q[v] == VC_IDLE || rc.release_i[v])) begin
            state_d[v] = VC_ROUTED;
            port_d[v]  = rc_port;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (rst) begin
            state_q[v] <= VC_IDLE;
            port_q[v]  <= LOCAL;
         end else begin
            state_q[v] <= state_d[v];
            port_q[v]  <= port_d[v];
         end
      end
   end

`ifdef RC_ERR_CHECK_EN
   logic err_q;
   logic err_d;

   always_comb begin
      err_d = err_q;
      for (int v = 0; v < VC_NUM; v++) begin
         if (vc_hit[v] && is_head && state_q[v] == VC_ROUTED && !rc.release_i[v]) err_d = 1'b1;
         if (vc_hit[v] && !is_head && state_q[v] == VC_IDLE) err_d = 1'b1;
      end
      if (rc.valid_i && is_head && rc_oor) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign rc.err_o = err_q;
`else
   logic unused_oor;
   assign unused_oor = rc_oor;
   assign rc.err_o   = 1'b0;
`endif

endmodule

`default_nettype wire
